seq_detect_param: RTL and testbench

//  Parametrised Moore sequence detector, successor to the fixed 10110 detectors.
//  - Pattern and length are set by parameters.
//  - Overlap vs non-overlap is selected at run time.
//  - Adds an input-valid qualifier and a saturating detection counter.

---
 rtl/seq_detect_param_pkg.sv | 51 +++++
 rtl/seq_detect_param_sat_counter.sv | 34 +++
 rtl/seq_detect_param.sv | 76 +++++++
 tb/tb_seq_detect_param.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_param_pkg.sv
// Shared types and elaboration-time helpers for the parametrised sequence detector.
package seq_det_pkg;

    localparam int unsigned MAX_PAT_LEN = 16;

    typedef enum logic {
        MODE_NON_OVERLAP = 1'b0,
        MODE_OVERLAP     = 1'b1
    } ovl_mode_e;

    function automatic int unsigned st_width(input int unsigned len);
        return $clog2(len + 1);
    endfunction

    // Longest prefix of the pattern that is a suffix of {prefix_k, b}.
    // Bit i of the pattern in arrival order is pattern[len-1-i].
    function automatic int unsigned kmp_next(input logic [MAX_PAT_LEN-1:0] pattern,
                                             input int unsigned len,
                                             input int unsigned k,
                                             input logic b);
        logic [MAX_PAT_LEN:0] s;
        int unsigned          best;
        logic                 ok;
        best = 0;
        s    = '0;
        for (int unsigned i = 0; i <= MAX_PAT_LEN; i++) begin
            if (i < k) begin
                s[i] = pattern[len - 1 - i];
            end else if (i == k) begin
                s[i] = b;
            end
        end
        for (int unsigned j = 1; j <= MAX_PAT_LEN; j++) begin
            if ((j <= k + 1) && (j <= len)) begin
                ok = 1'b1;
                for (int unsigned i = 0; i < MAX_PAT_LEN; i++) begin
                    if (i < j) begin
                        if (pattern[len - 1 - i] != s[k + 1 - j + i]) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = j;
                end
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter; a synchronous clear wins over a simultaneous increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised Moore sequence detector with run-time overlap select and a saturating hit counter.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int unsigned         PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0]  PATTERN = 5'b10110,
    parameter int unsigned         CNT_W   = 8,
    localparam int unsigned        ST_W    = $clog2(PAT_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_valid,
    input  logic             data,
    input  logic             mode_overlap,
    input  logic             clear_count,
    output logic             detected,
    output logic [ST_W-1:0]  state_o,
    output logic [CNT_W-1:0] det_count
);

    localparam logic [ST_W-1:0] S_LAST = ST_W'(PAT_LEN);

    logic [ST_W-1:0] state_q;
    logic [ST_W-1:0] state_d;
    logic            hit;
    ovl_mode_e       mode;
    logic [ST_W-1:0] nxt_tbl [PAT_LEN+1][2];

    // Whole transition table is folded to constants at elaboration.
    for (genvar k = 0; k <= PAT_LEN; k++) begin : g_state
        for (genvar bb = 0; bb < 2; bb++) begin : g_bit
            localparam int unsigned NXT =
                kmp_next(MAX_PAT_LEN'(PATTERN), PAT_LEN, k, 1'(bb));
            assign nxt_tbl[k][bb] = ST_W'(NXT);
        end
    end

    assign mode = ovl_mode_e'(mode_overlap);

    always_comb begin
        state_d = state_q;
        hit     = 1'b0;
        if (data_valid) begin
            if (state_q > S_LAST) begin
                state_d = '0;
            end else if ((state_q == S_LAST) && (mode == MODE_NON_OVERLAP)) begin
                state_d = nxt_tbl[0][data];
            end else begin
                state_d = nxt_tbl[state_q][data];
            end
            hit = (state_d == S_LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign detected = (state_q == S_LAST);
    assign state_o  = state_q;

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk_i  (clk),
        .rst_i  (reset),
        .inc_i  (hit),
        .clr_i  (clear_count),
        .count_o(det_count)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default pattern, all-ones pattern and a 2-bit counter.
module tb_seq_detect_param;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic data_valid = 1'b0;
    logic data = 1'b0;
    logic mode_overlap = 1'b1;
    logic clear_count = 1'b0;

    logic       det_d, det_o, det_s;
    logic [2:0] st_d, st_o, st_s;
    logic [7:0] cnt_d;
    logic [7:0] cnt_o;
    logic [1:0] cnt_s;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    seq_detect_param u_def (
        .clk(clk), .reset(reset), .data_valid(data_valid), .data(data),
        .mode_overlap(mode_overlap), .clear_count(clear_count),
        .detected(det_d), .state_o(st_d), .det_count(cnt_d)
    );

    seq_detect_param #(
        .PAT_LEN(4), .PATTERN(4'b1111), .CNT_W(8)
    ) u_ones (
        .clk(clk), .reset(reset), .data_valid(data_valid), .data(data),
        .mode_overlap(mode_overlap), .clear_count(clear_count),
        .detected(det_o), .state_o(st_o), .det_count(cnt_o)
    );

    seq_detect_param #(
        .PAT_LEN(5), .PATTERN(5'b10110), .CNT_W(2)
    ) u_sat (
        .clk(clk), .reset(reset), .data_valid(data_valid), .data(data),
        .mode_overlap(mode_overlap), .clear_count(clear_count),
        .detected(det_s), .state_o(st_s), .det_count(cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic b);
        data_valid = v;
        data       = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        data_valid = 1'b0;
        reset      = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [7:0] s10 [8]  = '{1, 0, 1, 1, 0, 1, 1, 0};
    logic [7:0] e_ov [8] = '{1, 2, 3, 4, 5, 3, 4, 5};
    logic [7:0] e_no [8] = '{1, 2, 3, 4, 5, 1, 1, 2};
    logic [7:0] e1_ov [6] = '{1, 2, 3, 4, 4, 4};
    logic [7:0] e1_no [6] = '{1, 2, 3, 4, 1, 2};

    initial begin
        #2;
        chk("rst_state", 32'(st_d), 0);
        chk("rst_det", 32'(det_d), 0);
        chk("rst_cnt", 32'(cnt_d), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: overlap on 10110110
        mode_overlap = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            step(1'b1, s10[i][0]);
            chk($sformatf("t1_state_%0d", i), 32'(st_d), 32'(e_ov[i]));
            chk($sformatf("t1_det_%0d", i), 32'(det_d), 32'(e_ov[i] == 5));
        end
        chk("t1_cnt", 32'(cnt_d), 2);

        // 2: non-overlap on same stream
        do_reset();
        mode_overlap = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            step(1'b1, s10[i][0]);
            chk($sformatf("t2_state_%0d", i), 32'(st_d), 32'(e_no[i]));
        end
        chk("t2_cnt", 32'(cnt_d), 1);

        // 3: 1111 pattern, six ones, both modes
        do_reset();
        mode_overlap = 1'b1;
        for (int unsigned i = 0; i < 6; i++) begin
            step(1'b1, 1'b1);
            chk($sformatf("t3o_state_%0d", i), 32'(st_o), 32'(e1_ov[i]));
            chk($sformatf("t3o_det_%0d", i), 32'(det_o), 32'(e1_ov[i] == 4));
        end
        chk("t3o_cnt", 32'(cnt_o), 3);
        do_reset();
        mode_overlap = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            step(1'b1, 1'b1);
            chk($sformatf("t3n_state_%0d", i), 32'(st_o), 32'(e1_no[i]));
        end
        chk("t3n_cnt", 32'(cnt_o), 1);

        // 4: valid gap between bits 3 and 4
        do_reset();
        mode_overlap = 1'b1;
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("t4_pre_gap", 32'(st_d), 3);
        for (int unsigned i = 0; i < 3; i++) begin
            step(1'b0, i[0]);
            chk($sformatf("t4_gap_state_%0d", i), 32'(st_d), 3);
            chk($sformatf("t4_gap_det_%0d", i), 32'(det_d), 0);
        end
        step(1'b1, 1'b1);
        chk("t4_state4", 32'(st_d), 4);
        step(1'b1, 1'b0);
        chk("t4_det", 32'(det_d), 1);
        chk("t4_cnt", 32'(cnt_d), 1);

        // 5: asynchronous reset mid-pattern (continues from S5, count=1)
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("t5_pre_state", 32'(st_d), 4);
        data_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_state", 32'(st_d), 0);
        chk("t5_async_cnt", 32'(cnt_d), 0);
        #1;
        reset = 1'b0;
        step(1'b1, 1'b0);
        chk("t5_after_state", 32'(st_d), 0);
        chk("t5_after_det", 32'(det_d), 0);
        chk("t5_after_cnt", 32'(cnt_d), 0);

        // 6: 2-bit counter saturation and clear priority
        do_reset();
        mode_overlap = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            step(1'b1, s10[i][0]);
        end
        chk("t6_cnt1", 32'(cnt_s), 1);
        for (int unsigned r = 0; r < 5; r++) begin
            step(1'b1, 1'b1);
            step(1'b1, 1'b1);
            step(1'b1, 1'b0);
            chk($sformatf("t6_det_%0d", r), 32'(det_s), 1);
            chk($sformatf("t6_cnt_%0d", r), 32'(cnt_s), (r + 2 > 3) ? 3 : r + 2);
        end
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        clear_count = 1'b1;
        step(1'b1, 1'b0);
        clear_count = 1'b0;
        chk("t6_clr_det", 32'(det_s), 1);
        chk("t6_clr_cnt", 32'(cnt_s), 0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        chk("t6_post_clr_cnt", 32'(cnt_s), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
